// File: rtl/fdtd_pkg.sv
// Shared types for the FDTD field-update sweep controllers.
// Tag entries carry a valid bit and the Ez read index that produced them.
package fdtd_pkg;

    localparam int FDTD_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fdtd_sweep_st_e;

    typedef struct packed {
        logic                   valid;
        logic [FDTD_ADDR_W-1:0] idx;
    } fdtd_tag_t;

    localparam fdtd_tag_t FDTD_TAG_NONE = '{valid: 1'b0, idx: '0};

endpackage

// File: rtl/fdtd_tag_pipe.sv
// Enabled shift register of fdtd_tag_t entries shadowing a fixed-latency datapath.
// occupied reports whether any stage still holds a valid tag.
module fdtd_tag_pipe
    import fdtd_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    input  fdtd_tag_t push_tag,
    output fdtd_tag_t pop_tag,
    output logic      occupied
);

    fdtd_tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= FDTD_TAG_NONE;
            end
        end else if (enable) begin
            stage[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_tag = stage[DEPTH-1];

    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied = occupied | stage[i].valid;
        end
    end

endmodule

// File: rtl/fdtd_hy_sweep_ctrl.sv
// Hy update sweep sequencer: Ez/Hy reads, calc clken, tag tracking, Hy write-back.
// Define FDTD_HY_PEC_EN to force the last cell's write data to zero (PEC wall).
module fdtd_hy_sweep_ctrl
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int ADDR_W          = FDTD_ADDR_W,
    parameter int MEM_RD_LAT      = 1,
    parameter int CALC_LATENCY    = 5,
    parameter int HY_SKEW         = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          n_cells_i,
    input  logic                       hold_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       ez_rd_en_o,
    output logic [ADDR_W-1:0]          ez_rd_addr_o,
    output logic                       hy_rd_en_o,
    output logic [ADDR_W-1:0]          hy_rd_addr_o,
    output logic                       calc_clken_o,
    input  logic [FDTD_DATA_WIDTH-1:0] hy_n_i,
    output logic                       wr_en_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [FDTD_DATA_WIDTH-1:0] wr_data_o
);

    localparam int TAG_DEPTH = MEM_RD_LAT + CALC_LATENCY;
    localparam logic [ADDR_W:0]   K_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fdtd_sweep_st_e state, state_nxt;

    logic [ADDR_W:0]   k;
    logic [ADDR_W-1:0] n_cells;
    logic              run;
    logic              issue;
    logic              last_k;
    logic              accept;

    fdtd_tag_t ez_push, hy_push;
    fdtd_tag_t wr_tag, hy_tag;
    logic      calc_busy, hy_busy;

    logic                       wr_vld;
    logic [ADDR_W-1:0]          wr_addr;
    logic [FDTD_DATA_WIDTH-1:0] wr_data;
    logic                       wr_fire;
    logic                       wall;

    assign run    = ~hold_i;
    assign issue  = (state == ISSUE);
    assign last_k = (k == {1'b0, n_cells});
    assign accept = (state == IDLE) && start_i && run;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (n_cells_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: if (run && last_k) state_nxt = DRAIN;
            DRAIN: if (run && !calc_busy && !hy_busy) state_nxt = DONE;
            DONE:  if (run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k       <= '0;
            n_cells <= '0;
        end else if (accept) begin
            k       <= '0;
            n_cells <= n_cells_i;
        end else if (run && issue) begin
            k <= k + K_ONE;
        end
    end

    // Hy read for cell k-1 trails Ez read k through its own skew pipe.
    always_comb begin
        ez_push.valid = issue;
        ez_push.idx   = FDTD_ADDR_W'(k);
        hy_push.valid = issue && (k != '0);
        hy_push.idx   = FDTD_ADDR_W'(k - K_ONE);
    end

    fdtd_tag_pipe #(
        .DEPTH(TAG_DEPTH)
    ) u_calc_tags (
        .clk     (CLK),
        .rst     (RST),
        .enable  (run),
        .push_tag(ez_push),
        .pop_tag (wr_tag),
        .occupied(calc_busy)
    );

    fdtd_tag_pipe #(
        .DEPTH(HY_SKEW)
    ) u_hy_skew (
        .clk     (CLK),
        .rst     (RST),
        .enable  (run),
        .push_tag(hy_push),
        .pop_tag (hy_tag),
        .occupied(hy_busy)
    );

    // idx 0 leaves the calc core as the priming sample and is dropped.
    assign wr_fire = wr_tag.valid && (wr_tag.idx != '0);

`ifdef FDTD_HY_PEC_EN
    assign wall = (wr_tag.idx == FDTD_ADDR_W'(n_cells));
`else
    assign wall = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_vld  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (run) begin
            wr_vld <= wr_fire;
            if (wr_fire) begin
                wr_addr <= ADDR_W'(wr_tag.idx) - A_ONE;
                wr_data <= wall ? '0 : hy_n_i;
            end
        end
    end

    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE) && run;
    assign calc_clken_o = busy_o && run;
    assign ez_rd_en_o   = issue && run;
    assign ez_rd_addr_o = k[ADDR_W-1:0];
    assign hy_rd_en_o   = hy_tag.valid && run;
    assign hy_rd_addr_o = ADDR_W'(hy_tag.idx);
    assign wr_en_o      = wr_vld && run;
    assign wr_addr_o    = wr_addr;
    assign wr_data_o    = wr_data;

endmodule

// File: tb/tb_fdtd_hy_sweep_ctrl.sv
// Bench for fdtd_hy_sweep_ctrl: sweep table, reset abort, random holds/data.
// Expectations come from an unfrozen-cycle timeline model of one sweep.
module tb_fdtd_hy_sweep_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int D  = 6;

    typedef struct {
        int n;
        int h1;
        int h1n;
        int h2;
        int h2n;
        int restart;
        int hprob;
        bit fixed;
        int exp_wr;
        int exp_done;
    } vec_t;

    logic          clk, rst, start_i, hold_i;
    logic [AW-1:0] n_cells_i;
    logic [DW-1:0] hy_n_i;
    logic          busy_o, done_o, ez_rd_en_o, hy_rd_en_o;
    logic          calc_clken_o, wr_en_o;
    logic [AW-1:0] ez_rd_addr_o, hy_rd_addr_o, wr_addr_o;
    logic [DW-1:0] wr_data_o;

    int n_pass = 0;
    int n_total = 0;

    fdtd_hy_sweep_ctrl dut (
        .CLK         (clk),
        .RST         (rst),
        .start_i     (start_i),
        .n_cells_i   (n_cells_i),
        .hold_i      (hold_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ez_rd_en_o  (ez_rd_en_o),
        .ez_rd_addr_o(ez_rd_addr_o),
        .hy_rd_en_o  (hy_rd_en_o),
        .hy_rd_addr_o(hy_rd_addr_o),
        .calc_clken_o(calc_clken_o),
        .hy_n_i      (hy_n_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Model: in unfrozen cycle u of the sweep, Ez read u (u<=N), Hy read
    // u-3, write u-D-2 with the hy_n_i seen in unfrozen cycle u-1, done at N+D+2.
    task automatic run_sweep(input vec_t v, output int writes,
                             output int dones, output int done_c);
        int u, c, limit;
        bit fin, held, e_ez, e_hy, e_wr, e_done;
        logic [DW-1:0] hist[$];
        logic [DW-1:0] e_data;
        u = 0; c = 0; fin = 0;
        writes = 0; dones = 0; done_c = -1;
        limit = v.n + D + 2 + v.h1n + v.h2n + 200;
        @(posedge clk); #1;
        start_i = 1'b1; hold_i = 1'b0;
        n_cells_i = AW'(v.n); hy_n_i = $urandom;
        @(negedge clk);
        chk("idle_before_start", {busy_o, done_o}, 0);
        while (!fin && c < limit) begin
            @(posedge clk); #1;
            held = ((c >= v.h1) && (c < v.h1 + v.h1n)) ||
                   ((c >= v.h2) && (c < v.h2 + v.h2n)) ||
                   (int'($urandom_range(99)) < v.hprob);
            hold_i = held;
            start_i = (c == v.restart);
            n_cells_i = AW'($urandom);
            hy_n_i = v.fixed ? 32'h1234 : $urandom;
            @(negedge clk);
            e_ez = !held && v.n > 0 && u <= v.n;
            e_hy = !held && v.n > 0 && u >= 3 && u <= v.n + 2;
            e_wr = !held && v.n > 0 && u >= D + 2 && u <= v.n + D + 1;
            e_done = !held && (v.n == 0 ? u == 0 : u == v.n + D + 2);
            chk("busy", busy_o, 1);
            chk("done", done_o, e_done);
            chk("clken", calc_clken_o, !held);
            chk("ez_en", ez_rd_en_o, e_ez);
            if (e_ez) chk("ez_addr", ez_rd_addr_o, u);
            chk("hy_en", hy_rd_en_o, e_hy);
            if (e_hy) chk("hy_addr", hy_rd_addr_o, u - 3);
            chk("wr_en", wr_en_o, e_wr);
            if (e_wr) begin
                e_data = hist[u-1];
`ifdef FDTD_HY_PEC_EN
                if (u - D - 2 == v.n - 1) e_data = '0;
`endif
                chk("wr_addr", wr_addr_o, u - D - 2);
                chk("wr_data", wr_data_o, e_data);
            end
            if (wr_en_o) writes++;
            if (done_o) begin
                dones++;
                done_c = c;
            end
            if (!held) begin
                hist.push_back(hy_n_i);
                if (e_done) fin = 1;
                u++;
            end
            c++;
        end
        if (!fin) chk("sweep_timeout", 0, 1);
        @(posedge clk); #1;
        hold_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("idle_after", {busy_o, done_o, ez_rd_en_o, wr_en_o}, 0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t rv;
        int wr, dn, dc, cnt;

        vecs.push_back('{4,    0, 0,  0, 0, -1, 0, 0, 4,    12});
        vecs.push_back('{0,    0, 0,  0, 0, -1, 0, 0, 0,    0});
        vecs.push_back('{8,    3, 3, 14, 2, -1, 0, 0, 8,    21});
        vecs.push_back('{8,    0, 0,  0, 0,  5, 0, 0, 8,    16});
        vecs.push_back('{1,    0, 0,  0, 0, -1, 0, 0, 1,    9});
        vecs.push_back('{3,    0, 0,  0, 0, -1, 0, 1, 3,    11});
        vecs.push_back('{1023, 0, 0,  0, 0, -1, 0, 0, 1023, 1031});

        rst = 1'b1; start_i = 1'b0; hold_i = 1'b0;
        n_cells_i = '0; hy_n_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {busy_o, done_o, ez_rd_en_o, hy_rd_en_o,
                          calc_clken_o, wr_en_o}, 0);
        chk("reset_addr", {ez_rd_addr_o, hy_rd_addr_o, wr_addr_o}, 0);
        chk("reset_data", wr_data_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_sweep(vecs[i], wr, dn, dc);
            chk("writes", wr, vecs[i].exp_wr);
            chk("done_count", dn, 1);
            chk("done_cycle", dc, vecs[i].exp_done);
        end

        // Abort mid-DRAIN with N=5, then a clean N=2 sweep.
        @(posedge clk); #1;
        start_i = 1'b1; n_cells_i = 10'd5; hold_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("drain_busy", busy_o, 1);
        rst = 1'b1;
        #1;
        chk("rst_ctl", {busy_o, done_o, ez_rd_en_o, hy_rd_en_o,
                        calc_clken_o, wr_en_o}, 0);
        chk("rst_data", {wr_addr_o, wr_data_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done_o || busy_o) cnt++;
        end
        chk("no_done_after_abort", cnt, 0);
        rv = '{2, 0, 0, 0, 0, -1, 0, 0, 2, 10};
        run_sweep(rv, wr, dn, dc);
        chk("post_rst_writes", wr, 2);
        chk("post_rst_done_cycle", dc, 10);

        for (int i = 0; i < 6; i++) begin
            rv = '{int'($urandom_range(20, 1)), 0, 0, 0, 0, -1, 25, 0, 0, -1};
            rv.exp_wr = rv.n;
            run_sweep(rv, wr, dn, dc);
            chk("rand_writes", wr, rv.exp_wr);
            chk("rand_done_count", dn, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
